// File: rtl/nfa_engine_pkg.sv
// Shared widths and helpers for the chained NFA match engine.
// Holds the position width and the per-state char-class select decoding.
package nfa_engine_pkg;

    localparam int POS_W      = 16;
    localparam int CLS_W      = 8;
    localparam int MAX_STATES = 64;

    function automatic logic [CLS_W-1:0] cls_idx(
        input logic [MAX_STATES*CLS_W-1:0] sel,
        input int                          i
    );
        return sel[i*CLS_W +: CLS_W];
    endfunction

endpackage

// File: rtl/nfa_state_cell.sv
// One link of the match chain: a flag that loads hit AND (pred OR self-loop).
// sod masks the stored flag so a restarting byte sees an empty chain.
module nfa_state_cell (
    input  logic clk,
    input  logic rst,
    input  logic sod,
    input  logic en,
    input  logic last,
    input  logic hit,
    input  logic pred,
    input  logic loop_en,
    output logic live,
    output logic nxt
);

    logic flag;

    assign live = flag & ~sod;
    assign nxt  = hit & (pred | (loop_en & live));

    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (en && last) begin
            flag <= 1'b0;
        end else if (en) begin
            flag <= nxt;
        end else if (sod) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/nfa_chain_engine.sv
// Chained-NFA byte matcher with a one-deep per-packet result slot.
// Tracks the first completing offset and flags results lost to a full slot.
module nfa_chain_engine
    import nfa_engine_pkg::*;
#(
    parameter int                        N_STATES  = 36,
    parameter int                        N_CLASS   = 40,
    parameter logic [N_STATES*CLS_W-1:0] CLS_SEL   = '0,
    parameter logic [N_STATES-1:0]       SELF_LOOP = '0,
    parameter bit                        ANCHORED  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sod,
    input  logic               en,
    input  logic               eod,
    input  logic [N_CLASS-1:0] cls_hit,
    output logic               match,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_match,
    output logic [POS_W-1:0]   res_pos,
    output logic               overrun
);

    localparam logic [MAX_STATES*CLS_W-1:0] SEL_EXT =
        (MAX_STATES*CLS_W)'(CLS_SEL);

    logic [N_STATES-1:0] live;
    logic [N_STATES-1:0] nxt;
    logic [N_STATES-1:0] pred;
    logic [N_STATES-1:0] hit;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    pos_eff;
    logic [POS_W-1:0]    first_pos;
    logic [POS_W-1:0]    first_eff;
    logic                match_eff;
    logic                last;
    logic                done;
    logic                slot_free;
    logic                unused_cls;

    assign unused_cls = ^cls_hit;
    assign last       = en & eod;
    assign pos_eff    = sod ? '0 : pos;
    assign first_eff  = sod ? '0 : first_pos;
    assign match_eff  = match & ~sod;
    assign done       = nxt[N_STATES-1];
    assign slot_free  = ~res_valid | res_ready;

    for (genvar i = 0; i < N_STATES; i++) begin : g_cell
        localparam int IDX = int'(cls_idx(SEL_EXT, i));
        if (IDX < N_CLASS) begin : g_hit
            assign hit[i] = cls_hit[IDX];
        end else begin : g_nohit
            assign hit[i] = 1'b0;
        end
        if (i == 0) begin : g_head
            assign pred[i] = ANCHORED ? (pos_eff == '0) : 1'b1;
        end else begin : g_link
            assign pred[i] = live[i-1];
        end
        nfa_state_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .sod     (sod),
            .en      (en),
            .last    (eod),
            .hit     (hit[i]),
            .pred    (pred[i]),
            .loop_en (SELF_LOOP[i]),
            .live    (live[i]),
            .nxt     (nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= '0;
            first_pos <= '0;
            match     <= 1'b0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_pos   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (en && !eod) begin
                pos   <= (pos_eff == '1) ? pos_eff : pos_eff + 1'b1;
                match <= match_eff | done;
                first_pos <= (done && !match_eff) ? pos_eff : first_eff;
            end else if (last || sod) begin
                pos       <= '0;
                match     <= 1'b0;
                first_pos <= '0;
            end
            // A full slot keeps the older result; the new one is lost.
            if (last && slot_free) begin
                res_valid <= 1'b1;
                res_match <= match_eff | done;
                res_pos   <= match_eff ? first_eff :
                             (done ? pos_eff : '0);
            end else if (last) begin
                overrun <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nfa_chain_engine.sv
// Bench for nfa_chain_engine: anchored and unanchored "ab+c" side by side.
// Expected results come from a string-level regex search over each packet.
module tb_nfa_chain_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        sod;
    logic        en;
    logic        eod;
    logic [7:0]  cls_hit;
    logic        res_ready;
    logic [1:0]  mt;
    logic [1:0]  rv;
    logic [1:0]  rm;
    logic [1:0]  ov;
    logic [15:0] rp [2];

    int checks   = 0;
    int failures = 0;

    byte pkt[$];
    bit  e_rv [2];
    bit  e_rm [2];
    int  e_rp [2];
    bit  e_ov [2];

    always #5 clk = ~clk;

    nfa_chain_engine #(
        .N_STATES(3), .N_CLASS(8), .CLS_SEL({8'd2, 8'd1, 8'd0}),
        .SELF_LOOP(3'b010), .ANCHORED(1'b1)
    ) u_anc (
        .clk(clk), .rst(rst), .sod(sod), .en(en), .eod(eod),
        .cls_hit(cls_hit), .match(mt[0]), .res_valid(rv[0]),
        .res_ready(res_ready), .res_match(rm[0]), .res_pos(rp[0]),
        .overrun(ov[0])
    );

    nfa_chain_engine #(
        .N_STATES(3), .N_CLASS(8), .CLS_SEL({8'd2, 8'd1, 8'd0}),
        .SELF_LOOP(3'b010), .ANCHORED(1'b0)
    ) u_una (
        .clk(clk), .rst(rst), .sod(sod), .en(en), .eod(eod),
        .cls_hit(cls_hit), .match(mt[1]), .res_valid(rv[1]),
        .res_ready(res_ready), .res_match(rm[1]), .res_pos(rp[1]),
        .overrun(ov[1])
    );

    // Earliest end index of a substring matching ab+c, or -1.
    function automatic int first_end(input byte q[$], input bit anch);
        for (int e = 2; e < q.size(); e++) begin
            if (q[e] == "c") begin
                for (int st = 0; st <= e - 2; st++) begin
                    bit ok;
                    if (anch && st != 0) break;
                    ok = (q[st] == "a");
                    for (int k = st + 1; k < e; k++)
                        if (q[k] != "b") ok = 1'b0;
                    if (ok) return e;
                end
            end
        end
        return -1;
    endfunction

    function automatic logic [7:0] sym_hits(input byte s);
        case (s)
            "a":     return 8'b0000_0001;
            "b":     return 8'b0000_0010;
            "c":     return 8'b0000_0100;
            default: return 8'b0010_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int fe;
            fe = first_end(pkt, k == 0);
            chk("match", k, 32'(mt[k]), 32'(pkt.size() > 0 && fe >= 0));
            chk("res_valid", k, 32'(rv[k]), 32'(e_rv[k]));
            chk("overrun", k, 32'(ov[k]), 32'(e_ov[k]));
            if (e_rv[k]) begin
                chk("res_match", k, 32'(rm[k]), 32'(e_rm[k]));
                chk("res_pos", k, 32'(rp[k]), 32'(e_rp[k]));
            end
        end
    endtask

    task automatic step(input bit s_sod, input bit s_en, input bit s_eod,
                        input byte sym, input bit rdy);
        sod       = s_sod;
        en        = s_en;
        eod       = s_eod;
        cls_hit   = s_en ? sym_hits(sym) : 8'($urandom);
        res_ready = rdy;
        if (s_sod) pkt.delete();
        if (s_en) pkt.push_back(sym);
        for (int k = 0; k < 2; k++) begin
            if (s_en && s_eod) begin
                int fe;
                fe = first_end(pkt, k == 0);
                if (!e_rv[k] || rdy) begin
                    e_rv[k] = 1'b1;
                    e_rm[k] = (fe >= 0);
                    e_rp[k] = (fe >= 0) ? fe : 0;
                end else begin
                    e_ov[k] = 1'b1;
                end
            end else if (e_rv[k] && rdy) begin
                e_rv[k] = 1'b0;
            end
        end
        if (s_en && s_eod) pkt.delete();
        @(posedge clk);
        #1;
        sod = 1'b0;
        en  = 1'b0;
        eod = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sod = 1'b1;
        en  = 1'b1;
        eod = 1'b1;
        cls_hit = 8'hff;
        res_ready = 1'b0;
        pkt.delete();
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 1'b0;
            e_rm[k] = 1'b0;
            e_rp[k] = 0;
            e_ov[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sod = 1'b0;
        en  = 1'b0;
        eod = 1'b0;
        check_all();
        for (int k = 0; k < 2; k++) begin
            chk("rst_res_match", k, 32'(rm[k]), 32'd0);
            chk("rst_res_pos", k, 32'(rp[k]), 32'd0);
        end
    endtask

    task automatic send(input string s, input bit with_eod, input bit rdy);
        for (int i = 0; i < s.len(); i++)
            step(1'b0, 1'b1, with_eod && (i == s.len() - 1), s[i], rdy);
    endtask

    initial begin
        rst = 1'b0;
        sod = 1'b0;
        en = 1'b0;
        eod = 1'b0;
        cls_hit = '0;
        res_ready = 1'b0;
        do_reset();

        send("abbc", 1'b0, 1'b1);
        chk("abbc_match", 0, 32'(mt[0]), 32'd1);
        step(1'b0, 1'b1, 1'b1, "x", 1'b1);
        chk("abbc_pos", 0, 32'(rp[0]), 32'd3);
        step(1'b0, 1'b0, 1'b0, "x", 1'b1);

        send("xabc", 1'b1, 1'b1);
        chk("xabc_anc", 0, 32'(rm[0]), 32'd0);
        chk("xabc_una", 1, 32'(rp[1]), 32'd3);
        step(1'b0, 1'b0, 1'b0, "x", 1'b1);

        send("abcabbc", 1'b1, 1'b1);
        chk("first_only", 1, 32'(rp[1]), 32'd2);
        step(1'b0, 1'b0, 1'b0, "x", 1'b1);

        send("abc", 1'b1, 1'b0);
        send("xab", 1'b1, 1'b0);
        send("abbbc", 1'b1, 1'b0);
        chk("retained", 0, 32'(rp[0]), 32'd2);
        chk("ovr_set", 1, 32'(ov[1]), 32'd1);
        step(1'b0, 1'b0, 1'b0, "x", 1'b1);
        chk("drained", 0, 32'(rv[0]), 32'd0);
        send("abc", 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, "x", 1'b0);
        send("abbc", 1'b1, 1'b1);
        chk("swap_pos", 0, 32'(rp[0]), 32'd3);
        step(1'b0, 1'b0, 1'b0, "x", 1'b1);

        do_reset();
        send("ab", 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, "a", 1'b1);
        send("bc", 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, "x", 1'b1);
        chk("sod_restart", 0, 32'(rp[0]), 32'd2);

        send("ab", 1'b0, 1'b1);
        do_reset();
        send("c", 1'b1, 1'b1);
        chk("rst_discard", 1, 32'(rm[1]), 32'd0);

        step(1'b0, 1'b0, 1'b1, "c", 1'b1);
        step(1'b1, 1'b0, 1'b0, "x", 1'b1);

        for (int n = 0; n < 600; n++) begin
            byte sym;
            int r;
            r = $urandom_range(0, 9);
            sym = (r < 3) ? "a" : (r < 7) ? "b" : (r < 9) ? "c" : "x";
            step($urandom_range(0, 24) == 0, $urandom_range(0, 5) != 0,
                 $urandom_range(0, 7) == 0, sym, $urandom_range(0, 2) != 0);
            if (n == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
